// File: rtl/turn_sequencer_if.sv
// turn_sequencer_if
//   Bundles the button, CPU-engine handshake and display-facing signals of
//   the tic-tac-toe game-flow controller.
//   slave  : view used by turn_sequencer (inputs from debouncer/engine,
//            outputs towards renderer, 7-segment display and engine).
//   master : view used by whoever drives the sequencer (top level or bench).
//   Signals:
//     btn_pulse[4:0]   one-cycle pulses: [0] center, [1] up, [2] down,
//                      [3] left, [4] right
//     cpu_mode         1 = CPU plays O (taken when a game starts)
//     cpu_move_valid   engine offers a move
//     cpu_move_idx     offered cell, 0..8 legal
//     cpu_move_req     sequencer wants a move from the engine
//     cpu_move_ack     one-cycle accept of an offered move
//     cpu_move_err     one-cycle reject of an offered move
//     board_x/board_o  bit i = mark in cell i (cell = row*3 + col)
//     cursor           highlighted cell, 0..8
//     winner           00 none, 01 X, 10 O, 11 draw
//     turn             0 = X to move, 1 = O to move
//     state            FSM state encoding
interface turn_sequencer_if;
  logic [4:0] btn_pulse;
  logic       cpu_mode;
  logic       cpu_move_valid;
  logic [3:0] cpu_move_idx;
  logic       cpu_move_req;
  logic       cpu_move_ack;
  logic       cpu_move_err;
  logic [8:0] board_x;
  logic [8:0] board_o;
  logic [3:0] cursor;
  logic [1:0] winner;
  logic       turn;
  logic [2:0] state;

  modport slave (
    input  btn_pulse, cpu_mode, cpu_move_valid, cpu_move_idx,
    output cpu_move_req, cpu_move_ack, cpu_move_err,
    output board_x, board_o, cursor, winner, turn, state
  );

  modport master (
    output btn_pulse, cpu_mode, cpu_move_valid, cpu_move_idx,
    input  cpu_move_req, cpu_move_ack, cpu_move_err,
    input  board_x, board_o, cursor, winner, turn, state
  );
endinterface

// File: rtl/turn_sequencer.sv
// turn_sequencer
//   Game-flow controller for the VGA tic-tac-toe design. Converts debounced
//   button pulses into cursor moves and mark placements, alternates turns
//   between X and O, and arbitrates the board-write path between a human O
//   player and an external CPU move engine.
//   Ports:
//     clk    system clock (debouncer domain)
//     reset  synchronous, active-low reset
//     bus    turn_sequencer_if.slave: buttons, CPU handshake, board/cursor/
//            winner/turn/state outputs. Every output is a register.
module turn_sequencer (
  input  logic             clk,
  input  logic             reset,
  turn_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    X_TURN = 3'd1,
    O_TURN = 3'd2,
    CHECK  = 3'd3,
    OVER   = 3'd4
  } state_t;

  localparam logic [3:0] CURSOR_HOME = 4'd4;
  localparam logic [3:0] FULL_BOARD  = 4'd9;

  // Eight winning lines as cell masks: rows, columns, then both diagonals.
  localparam logic [71:0] LINE_MASKS = {
    9'h054, 9'h111,                 // anti-diagonal 2,4,6 ; diagonal 0,4,8
    9'h124, 9'h092, 9'h049,         // columns 2, 1, 0
    9'h1C0, 9'h038, 9'h007          // rows 2, 1, 0
  };

  state_t     state_reg, state_next;
  logic [8:0] board_x_reg, board_x_next;
  logic [8:0] board_o_reg, board_o_next;
  logic [3:0] cursor_reg, cursor_next;
  logic [3:0] move_count_reg, move_count_next;
  logic [1:0] winner_reg, winner_next;
  logic       turn_reg, turn_next;
  logic       cpu_mode_reg, cpu_mode_next;
  logic       req_reg, req_next;
  logic       ack_reg, ack_next;
  logic       err_reg, err_next;

  logic [7:0] line_x, line_o;
  logic [8:0] cursor_cell;
  logic [8:0] cpu_cell;
  logic       cursor_free;
  logic       cpu_move_ok;
  logic [3:0] move_count_inc;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_line
      localparam logic [8:0] MASK = LINE_MASKS[gi*9 +: 9];
      assign line_x[gi] = ((board_x_reg & MASK) == MASK);
      assign line_o[gi] = ((board_o_reg & MASK) == MASK);
    end
  endgenerate

  // One-hot cell selects; an index above 8 shifts out to zero, which makes
  // out-of-range CPU offers fall through as illegal without a range compare.
  assign cursor_cell = 9'b1 << cursor_reg;
  assign cpu_cell    = 9'b1 << bus.cpu_move_idx;
  assign cursor_free = ((board_x_reg | board_o_reg) & cursor_cell) == 9'd0;
  assign cpu_move_ok = (cpu_cell != 9'd0) &&
                       (((board_x_reg | board_o_reg) & cpu_cell) == 9'd0);
  assign move_count_inc = (move_count_reg == FULL_BOARD) ? FULL_BOARD
                                                         : move_count_reg + 4'd1;

  function automatic logic [3:0] cursor_up(input logic [3:0] c);
    return (c >= 4'd3) ? c - 4'd3 : c + 4'd6;
  endfunction

  function automatic logic [3:0] cursor_down(input logic [3:0] c);
    return (c <= 4'd5) ? c + 4'd3 : c - 4'd6;
  endfunction

  function automatic logic [3:0] cursor_left(input logic [3:0] c);
    return (c == 4'd0 || c == 4'd3 || c == 4'd6) ? c + 4'd2 : c - 4'd1;
  endfunction

  function automatic logic [3:0] cursor_right(input logic [3:0] c);
    return (c == 4'd2 || c == 4'd5 || c == 4'd8) ? c - 4'd2 : c + 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      board_x_reg    <= 9'd0;
      board_o_reg    <= 9'd0;
      cursor_reg     <= CURSOR_HOME;
      move_count_reg <= 4'd0;
      winner_reg     <= 2'b00;
      turn_reg       <= 1'b0;
      cpu_mode_reg   <= 1'b0;
      req_reg        <= 1'b0;
      ack_reg        <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      board_x_reg    <= board_x_next;
      board_o_reg    <= board_o_next;
      cursor_reg     <= cursor_next;
      move_count_reg <= move_count_next;
      winner_reg     <= winner_next;
      turn_reg       <= turn_next;
      cpu_mode_reg   <= cpu_mode_next;
      req_reg        <= req_next;
      ack_reg        <= ack_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    board_x_next    = board_x_reg;
    board_o_next    = board_o_reg;
    cursor_next     = cursor_reg;
    move_count_next = move_count_reg;
    winner_next     = winner_reg;
    turn_next       = turn_reg;
    cpu_mode_next   = cpu_mode_reg;
    ack_next        = 1'b0;
    err_next        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.btn_pulse[0]) begin
          cpu_mode_next = bus.cpu_mode;
          state_next    = X_TURN;
        end
      end

      X_TURN, O_TURN: begin
        if (state_reg == O_TURN && cpu_mode_reg) begin
          // Engine owns the board-write path; buttons are ignored here.
          if (bus.cpu_move_valid) begin
            if (cpu_move_ok) begin
              ack_next        = 1'b1;
              board_o_next    = board_o_reg | cpu_cell;
              cursor_next     = bus.cpu_move_idx;
              move_count_next = move_count_inc;
              state_next      = CHECK;
            end else begin
              err_next = 1'b1;
            end
          end
        end else if (bus.btn_pulse[0]) begin
          // Center always wins priority, even when the cell is taken and
          // the press therefore does nothing.
          if (cursor_free) begin
            if (state_reg == X_TURN) board_x_next = board_x_reg | cursor_cell;
            else                     board_o_next = board_o_reg | cursor_cell;
            move_count_next = move_count_inc;
            state_next      = CHECK;
          end
        end else if (bus.btn_pulse[1]) begin
          cursor_next = cursor_up(cursor_reg);
        end else if (bus.btn_pulse[2]) begin
          cursor_next = cursor_down(cursor_reg);
        end else if (bus.btn_pulse[3]) begin
          cursor_next = cursor_left(cursor_reg);
        end else if (bus.btn_pulse[4]) begin
          cursor_next = cursor_right(cursor_reg);
        end
      end

      CHECK: begin
        // A line completed on the ninth move is a win, so lines are tested
        // before the full-board draw condition.
        if (|line_x) begin
          winner_next = 2'b01;
          state_next  = OVER;
        end else if (|line_o) begin
          winner_next = 2'b10;
          state_next  = OVER;
        end else if (move_count_reg == FULL_BOARD) begin
          winner_next = 2'b11;
          state_next  = OVER;
        end else begin
          turn_next  = ~turn_reg;
          state_next = turn_reg ? X_TURN : O_TURN;
        end
      end

      OVER: begin
        if (bus.btn_pulse[0]) begin
          board_x_next    = 9'd0;
          board_o_next    = 9'd0;
          winner_next     = 2'b00;
          move_count_next = 4'd0;
          turn_next       = 1'b0;
          cursor_next     = CURSOR_HOME;
          state_next      = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    // Registered request: high exactly while the next state is CPU O_TURN,
    // so it drops on the same edge that accepts the move.
    req_next = (state_next == O_TURN) && cpu_mode_next;
  end

  assign bus.state        = state_reg;
  assign bus.board_x      = board_x_reg;
  assign bus.board_o      = board_o_reg;
  assign bus.cursor       = cursor_reg;
  assign bus.winner       = winner_reg;
  assign bus.turn         = turn_reg;
  assign bus.cpu_move_req = req_reg;
  assign bus.cpu_move_ack = ack_reg;
  assign bus.cpu_move_err = err_reg;

endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer
//   Directed game scenarios followed by random button/engine traffic. A
//   behavioural model (cell array, row/column arithmetic, line search) tracks
//   the expected outputs after every clock edge and each output is compared.
module tb_turn_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  turn_sequencer_if bus();

  turn_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad = 0;

  // Model of the game as seen from outside.
  int         e_state;
  logic [8:0] e_bx, e_bo;
  int         e_cursor, e_winner, e_moves;
  logic       e_turn, e_cpu, e_req, e_ack, e_err;

  function automatic bit has_line(input logic [8:0] b);
    for (int r = 0; r < 3; r++)
      if (b[r*3] && b[r*3+1] && b[r*3+2]) return 1'b1;
    for (int c = 0; c < 3; c++)
      if (b[c] && b[c+3] && b[c+6]) return 1'b1;
    if (b[0] && b[4] && b[8]) return 1'b1;
    if (b[2] && b[4] && b[6]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge(input logic rst_n, input logic [4:0] btn,
                            input logic cmode, input logic v, input logic [3:0] idx);
    int row, col, i;
    e_ack = 1'b0;
    e_err = 1'b0;
    if (!rst_n) begin
      e_state = 0; e_bx = '0; e_bo = '0; e_cursor = 4; e_winner = 0;
      e_turn = 1'b0; e_moves = 0; e_cpu = 1'b0; e_req = 1'b0;
      return;
    end
    row = e_cursor / 3;
    col = e_cursor % 3;
    i = int'(idx);
    case (e_state)
      0: if (btn[0]) begin e_cpu = cmode; e_state = 1; end
      1, 2: begin
        if (e_state == 2 && e_cpu) begin
          if (v) begin
            if (i <= 8 && !e_bx[i] && !e_bo[i]) begin
              e_ack = 1'b1; e_bo[i] = 1'b1; e_cursor = i;
              if (e_moves < 9) e_moves++;
              e_state = 3;
            end else begin
              e_err = 1'b1;
            end
          end
        end else if (btn[0]) begin
          if (!e_bx[e_cursor] && !e_bo[e_cursor]) begin
            if (e_state == 1) e_bx[e_cursor] = 1'b1;
            else              e_bo[e_cursor] = 1'b1;
            if (e_moves < 9) e_moves++;
            e_state = 3;
          end
        end else if (btn[1]) e_cursor = ((row + 2) % 3) * 3 + col;
        else if (btn[2])     e_cursor = ((row + 1) % 3) * 3 + col;
        else if (btn[3])     e_cursor = row * 3 + (col + 2) % 3;
        else if (btn[4])     e_cursor = row * 3 + (col + 1) % 3;
      end
      3: begin
        if (has_line(e_bx))      begin e_winner = 1; e_state = 4; end
        else if (has_line(e_bo)) begin e_winner = 2; e_state = 4; end
        else if (e_moves == 9)   begin e_winner = 3; e_state = 4; end
        else begin
          e_turn = !e_turn;
          e_state = e_turn ? 2 : 1;
        end
      end
      4: if (btn[0]) begin
        e_bx = '0; e_bo = '0; e_winner = 0; e_moves = 0; e_turn = 1'b0;
        e_cursor = 4; e_state = 0;
      end
      default: ;
    endcase
    e_req = (e_state == 2) && e_cpu;
  endtask

  task automatic chk(input string tag, input string field,
                     input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s.%s got=%0h want=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk(tag, "state",  9'(bus.state),        9'(e_state));
    chk(tag, "bx",     bus.board_x,          e_bx);
    chk(tag, "bo",     bus.board_o,          e_bo);
    chk(tag, "cursor", 9'(bus.cursor),       9'(e_cursor));
    chk(tag, "winner", 9'(bus.winner),       9'(e_winner));
    chk(tag, "turn",   9'(bus.turn),         9'(e_turn));
    chk(tag, "req",    9'(bus.cpu_move_req), 9'(e_req));
    chk(tag, "ack",    9'(bus.cpu_move_ack), 9'(e_ack));
    chk(tag, "err",    9'(bus.cpu_move_err), 9'(e_err));
  endtask

  // One clock edge of stimulus, then compare every output #1 after the edge.
  task automatic step(input string tag, input logic [4:0] btn,
                      input logic v, input logic [3:0] idx);
    bus.btn_pulse      = btn;
    bus.cpu_move_valid = v;
    bus.cpu_move_idx   = idx;
    @(posedge clk);
    model_edge(reset, btn, bus.cpu_mode, v, idx);
    #1;
    bus.btn_pulse      = 5'b0;
    bus.cpu_move_valid = 1'b0;
    check_all(tag);
    $display("%-14s btn=%05b v=%0d idx=%0d | state=%0d cur=%0d bx=%03h bo=%03h win=%0d turn=%0d req=%0d ack=%0d err=%0d",
             tag, btn, v, idx, bus.state, bus.cursor, bus.board_x, bus.board_o,
             bus.winner, bus.turn, bus.cpu_move_req, bus.cpu_move_ack, bus.cpu_move_err);
  endtask

  // Steer the cursor with down/right pulses, place with center, then let
  // CHECK resolve.
  task automatic place_at(input int target, input string tag);
    for (int k = 0; k < 6 && e_cursor != target; k++) begin
      if (e_cursor / 3 != target / 3) step(tag, 5'b00100, 1'b0, 4'd0);
      else                            step(tag, 5'b10000, 1'b0, 4'd0);
    end
    step(tag, 5'b00001, 1'b0, 4'd0);
    step(tag, 5'b00000, 1'b0, 4'd0);
  endtask

  initial begin
    bus.btn_pulse      = 5'b0;
    bus.cpu_mode       = 1'b0;
    bus.cpu_move_valid = 1'b0;
    bus.cpu_move_idx   = 4'd0;

    // Reset values
    reset = 1'b0;
    step("reset", 5'b00001, 1'b1, 4'd3);
    reset = 1'b1;
    chk("reset", "cursor_const", 9'(bus.cursor), 9'd4);

    // Human game: X completes the top row
    step("start", 5'b00001, 1'b0, 4'd0);
    place_at(0, "x0");
    place_at(3, "o3");
    place_at(1, "x1");
    place_at(4, "o4");
    place_at(2, "x2");
    chk("xwin", "bx_const", bus.board_x, 9'b000000111);
    chk("xwin", "win_const", 9'(bus.winner), 9'd1);
    chk("xwin", "state_const", 9'(bus.state), 9'd4);
    step("over_dir", 5'b11110, 1'b0, 4'd0);
    step("restart", 5'b00001, 1'b0, 4'd0);

    // Cursor wrap from 4
    step("start2", 5'b00001, 1'b0, 4'd0);
    step("up", 5'b00010, 1'b0, 4'd0);
    chk("up1", "cur_const", 9'(bus.cursor), 9'd1);
    step("up", 5'b00010, 1'b0, 4'd0);
    chk("up2", "cur_const", 9'(bus.cursor), 9'd7);
    step("left", 5'b01000, 1'b0, 4'd0);
    chk("left1", "cur_const", 9'(bus.cursor), 9'd6);
    step("left", 5'b01000, 1'b0, 4'd0);
    chk("left2", "cur_const", 9'(bus.cursor), 9'd8);
    step("right", 5'b10000, 1'b0, 4'd0);
    chk("right", "cur_const", 9'(bus.cursor), 9'd6);

    // Occupied cell, then simultaneous up+center
    step("x6", 5'b00001, 1'b0, 4'd0);
    step("x6_chk", 5'b00000, 1'b0, 4'd0);
    step("o_occupied", 5'b00001, 1'b0, 4'd0);
    chk("occ", "state_const", 9'(bus.state), 9'd2);
    step("o_right", 5'b10000, 1'b0, 4'd0);
    step("up_center", 5'b00011, 1'b0, 4'd0);
    chk("upc", "cur_const", 9'(bus.cursor), 9'd7);
    step("upc_chk", 5'b00000, 1'b0, 4'd0);

    // CPU mode handshake
    reset = 1'b0;
    step("reset_cpu", 5'b00000, 1'b0, 4'd0);
    reset = 1'b1;
    bus.cpu_mode = 1'b1;
    step("cpu_start", 5'b00001, 1'b0, 4'd0);
    bus.cpu_mode = 1'b0;
    step("x_v_ignored", 5'b00000, 1'b1, 4'd0);
    place_at(4, "cpu_x4");
    step("cpu_btn_ign", 5'b00011, 1'b0, 4'd0);
    step("cpu_occ", 5'b00000, 1'b1, 4'd4);
    chk("cpu_occ", "err_const", 9'(bus.cpu_move_err), 9'd1);
    step("cpu_gap", 5'b00000, 1'b0, 4'd0);
    step("cpu_idx15", 5'b00000, 1'b1, 4'd15);
    step("cpu_hold1", 5'b00000, 1'b1, 4'd9);
    step("cpu_hold2", 5'b00000, 1'b1, 4'd9);
    step("cpu_ok", 5'b00000, 1'b1, 4'd0);
    chk("cpu_ok", "bo_const", bus.board_o, 9'b000000001);
    chk("cpu_ok", "req_const", 9'(bus.cpu_move_req), 9'd0);
    step("cpu_after", 5'b00000, 1'b1, 4'd0);
    chk("cpu_after", "turn_const", 9'(bus.turn), 9'd0);

    // Draw game in human mode
    reset = 1'b0;
    step("reset_draw", 5'b00000, 1'b0, 4'd0);
    reset = 1'b1;
    step("draw_start", 5'b00001, 1'b0, 4'd0);
    place_at(0, "d_x0");
    place_at(1, "d_o1");
    place_at(2, "d_x2");
    place_at(4, "d_o4");
    place_at(3, "d_x3");
    place_at(5, "d_o5");
    place_at(7, "d_x7");
    place_at(6, "d_o6");
    place_at(8, "d_x8");
    chk("draw", "win_const", 9'(bus.winner), 9'd3);
    step("draw_clear", 5'b00001, 1'b0, 4'd0);
    chk("draw_clear", "bx_const", bus.board_x, 9'd0);
    step("again", 5'b00001, 1'b0, 4'd0);
    place_at(0, "again_x0");
    reset = 1'b0;
    step("reset_in_o", 5'b00001, 1'b1, 4'd1);
    reset = 1'b1;

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [4:0] b;
      logic       v;
      logic [3:0] ix;
      b = 5'b0;
      for (int k = 0; k < 5; k++)
        if ($urandom_range(0, 5) == 0) b[k] = 1'b1;
      v  = ($urandom_range(0, 2) == 0);
      ix = 4'($urandom_range(0, 15));
      bus.cpu_mode = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 99) != 0);
      step("rand", b, v, ix);
    end
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
